// File: rtl/enemy_spawner_pkg.sv
// Shared definitions for the enemy spawner: game state encoding, LFSR taps
// and the layout of the 6-bit rand bus handed to the enemy slots.
package enemy_spawner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam int          LFSR_W       = 16;
  localparam int          ANGLE_STATES = 16;
  localparam int          ANGLE_W      = 4;
  localparam int          TYPE_W       = 2;
  localparam int          RAND_W       = ANGLE_W + TYPE_W;
  localparam int          TIMER_W      = 26;
  localparam int          WAVE_W       = 4;

  // Rand bus: angle in [5:2], enemy type in [1:0].
  typedef struct packed {
    logic [ANGLE_W-1:0] angle;
    logic [TYPE_W-1:0]  etype;
  } rand_t;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Push a repeated angle to the opposite side of the circle.
  function automatic logic [ANGLE_W-1:0] pick_angle(input logic [ANGLE_W-1:0] cand,
                                                   input logic [ANGLE_W-1:0] last);
    pick_angle = (cand == last) ? cand + ANGLE_W'(ANGLE_STATES / 2) : cand;
  endfunction

endpackage

// File: rtl/enemy_spawner_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes only the low bits used to draw
// the angle and type of a new enemy.
module spawn_lfsr
  import enemy_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [RAND_W-1:0] rand_src
);

  logic [LFSR_W-1:0] lfsr_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign rand_src = lfsr_q[RAND_W-1:0];

endmodule

// File: rtl/enemy_spawner.sv
// Spawn scheduler for the enemy slots: owns the IDLE/RUN/OVER game state,
// picks the lowest free slot on each timer expiry and ramps difficulty by wave.
module enemy_spawner
  import enemy_spawner_pkg::*;
#(
  parameter int          NUM_SLOTS       = 4,
  parameter int          INIT_INTERVAL   = 50000000,
  parameter int          MIN_INTERVAL    = 12500000,
  parameter int          INTERVAL_STEP   = 2500000,
  parameter int          SPAWNS_PER_WAVE = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] enemy_alive,
  input  logic [NUM_SLOTS-1:0] enemy_collision,
  output logic [NUM_SLOTS-1:0] spawn,
  output logic [RAND_W-1:0]    rand_bits,
  output logic                 enable,
  output logic                 game_over,
  output logic [WAVE_W-1:0]    wave
);

  localparam int CNT_W = (SPAWNS_PER_WAVE > 1) ? $clog2(SPAWNS_PER_WAVE) : 1;

  localparam logic [TIMER_W-1:0] INIT_IV  = TIMER_W'(INIT_INTERVAL);
  localparam logic [TIMER_W-1:0] MIN_IV   = TIMER_W'(MIN_INTERVAL);
  localparam logic [TIMER_W-1:0] STEP_IV  = TIMER_W'(INTERVAL_STEP);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SPAWNS_PER_WAVE - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   interval;
  logic [TIMER_W-1:0]   next_interval;
  logic [CNT_W-1:0]     spawn_cnt;
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] pending_kept;
  logic [NUM_SLOTS-1:0] coll_q;
  logic [NUM_SLOTS-1:0] coll_rise;
  logic [NUM_SLOTS-1:0] free;
  logic [NUM_SLOTS-1:0] sel;
  logic                 found;
  logic [ANGLE_W-1:0]   last_angle;
  logic [RAND_W-1:0]    rand_src;
  rand_t                next_rand;

  spawn_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_src (rand_src)
  );

  assign coll_rise    = enemy_collision & ~coll_q;
  assign free         = ~enemy_alive & ~pending;
  // A slot stays reserved from its spawn pulse until it reports alive.
  assign pending_kept = pending & ~enemy_alive;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    next_rand.angle = pick_angle(rand_src[RAND_W-1:TYPE_W], last_angle);
    next_rand.etype = rand_src[TYPE_W-1:0];
    if (wave < WAVE_W'(2)) next_rand.etype[1] = 1'b1;
  end

  // Subtraction is guarded so the interval never wraps below the floor.
  always_comb begin
    next_interval = MIN_IV;
    if (interval >= MIN_IV && (interval - MIN_IV) >= STEP_IV)
      next_interval = interval - STEP_IV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      spawn      <= '0;
      rand_bits  <= '0;
      enable     <= 1'b0;
      game_over  <= 1'b0;
      wave       <= '0;
      timer      <= '0;
      interval   <= INIT_IV;
      spawn_cnt  <= '0;
      pending    <= '0;
      last_angle <= 4'hF;
      coll_q     <= '0;
    end else begin
      coll_q  <= enemy_collision;
      spawn   <= '0;
      pending <= pending_kept;

      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= RUN;
            enable    <= 1'b1;
            game_over <= 1'b0;
            timer     <= INIT_IV - 1'b1;
            interval  <= INIT_IV;
            wave      <= '0;
            spawn_cnt <= '0;
            pending   <= '0;
          end
        end

        RUN: begin
          if (|coll_rise) begin
            state     <= OVER;
            enable    <= 1'b0;
            game_over <= 1'b1;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (found) begin
            spawn      <= sel;
            rand_bits  <= next_rand;
            last_angle <= next_rand.angle;
            pending    <= pending_kept | sel;
            // Reload uses the interval in force before this wave update.
            timer      <= interval - 1'b1;
            if (spawn_cnt == LAST_CNT) begin
              spawn_cnt <= '0;
              wave      <= (wave == '1) ? wave : wave + 1'b1;
              interval  <= next_interval;
            end else begin
              spawn_cnt <= spawn_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          enable    <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_spawner.sv
// Scoreboard bench for enemy_spawner: stimulus pushes expected spawn events,
// a negedge monitor pops and compares them whenever a spawn pulse appears.
module tb_enemy_spawner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] man_alive = 2'b00;
  logic [1:0] emu_alive = 2'b00;
  logic       emu_en = 1'b0;
  logic [1:0] enemy_alive;
  logic [1:0] enemy_collision = 2'b00;
  logic [1:0] spawn;
  logic [5:0] rand_bits;
  logic       enable;
  logic       game_over;
  logic [3:0] wave;

  assign enemy_alive = man_alive | (emu_en ? emu_alive : 2'b00);

  enemy_spawner #(
    .NUM_SLOTS       (2),
    .INIT_INTERVAL   (10),
    .MIN_INTERVAL    (4),
    .INTERVAL_STEP   (3),
    .SPAWNS_PER_WAVE (2),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .enemy_alive     (enemy_alive),
    .enemy_collision (enemy_collision),
    .spawn           (spawn),
    .rand_bits       (rand_bits),
    .enable          (enable),
    .game_over       (game_over),
    .wave            (wave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int slot;
    int wave_before;
    int wave_after;
  } exp_t;

  exp_t sb[$];

  // Reference LFSR; m_prev is the value the DUT held just before the last edge.
  logic [15:0] m_lfsr  = 16'h0000;
  logic [15:0] m_prev  = 16'h0000;
  int          rst_cnt = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_prev <= m_lfsr;
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      rst_cnt <= rst_cnt + 1;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int slot, input int wb, input int wa);
    exp_t e;
    e.cyc = c; e.slot = slot; e.wave_before = wb; e.wave_after = wa;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Slot emulator: a spawned slot reports alive for one cycle, two cycles later.
  int ecnt [2] = '{0, 0};
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        emu_alive[i] = 1'b0;
        if (ecnt[i] != 0) begin
          ecnt[i]--;
          if (ecnt[i] == 0) emu_alive[i] = 1'b1;
        end
        if (spawn[i]) ecnt[i] = 2;
      end
    end
  end

  // Monitor
  logic [3:0] m_last   = 4'hF;
  logic [3:0] prev_ang = 4'h0;
  bit         have_prev = 1'b0;
  int         seen_rst  = 0;
  initial begin
    exp_t       e;
    logic [3:0] ea;
    logic [1:0] et;
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst) begin
        seen_rst  = rst_cnt;
        m_last    = 4'hF;
        have_prev = 1'b0;
      end
      if (spawn != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_spawn", 32'(spawn), 32'd0);
        end else begin
          e = sb.pop_front();
          check("spawn_slot", 32'(spawn), 32'(1 << e.slot));
          check("spawn_cycle", 32'(cyc), 32'(e.cyc));
          check("wave_after_spawn", 32'(wave), 32'(e.wave_after));
          ea = (m_prev[5:2] == m_last) ? m_prev[5:2] + 4'd8 : m_prev[5:2];
          et = m_prev[1:0] | ((e.wave_before < 2) ? 2'b10 : 2'b00);
          check("rand", 32'(rand_bits), 32'({ea, et}));
          m_last = ea;
          if (e.wave_before < 2) check("weak_type", 32'(rand_bits[1]), 32'd1);
          if (have_prev) check("angle_repeat", 32'(rand_bits[5:2] == prev_ang), 32'd0);
          prev_ang  = rand_bits[5:2];
          have_prev = 1'b1;
        end
      end
    end
  end

  // Stimulus
  int base;
  initial begin
    repeat (2) @(negedge clk);
    check("rst_spawn", 32'(spawn), 32'd0);
    check("rst_rand", 32'(rand_bits), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_wave", 32'(wave), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0000ACE1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First spawn 10 cycles after the start edge.
    base  = cyc;
    start = 1'b1;
    push(base + 11, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    check("run_enable", 32'(enable), 32'd1);
    check("run_game_over", 32'(game_over), 32'd0);
    check("run_wave", 32'(wave), 32'd0);

    // Slot 0 comes alive late; then both slots full across timer expiry.
    at_cyc(base + 13); man_alive = 2'b01;
    at_cyc(base + 15); man_alive = 2'b11;
    push(base + 26, 1, 0, 1);
    at_cyc(base + 25); man_alive = 2'b01;
    at_cyc(base + 26); man_alive = 2'b00; emu_en = 1'b1;

    // Wave ramp with slots freed continuously.
    push(base + 36, 0, 1, 1);
    push(base + 43, 0, 1, 2);
    push(base + 50, 0, 2, 2);
    push(base + 54, 0, 2, 3);
    push(base + 58, 0, 3, 3);
    at_cyc(base + 40); start = 1'b1;
    at_cyc(base + 41); start = 1'b0;
    at_cyc(base + 45);
    check("mid_wave", 32'(wave), 32'd2);
    check("mid_enable", 32'(enable), 32'd1);

    // Collision in the cycle the timer reaches zero.
    at_cyc(base + 61); enemy_collision = 2'b01;
    at_cyc(base + 62);
    check("over_game_over", 32'(game_over), 32'd1);
    check("over_enable", 32'(enable), 32'd0);
    check("over_spawn", 32'(spawn), 32'd0);

    // Restart with the collision held high.
    at_cyc(base + 64); start = 1'b1;
    push(base + 75, 0, 0, 0);
    at_cyc(base + 65); start = 1'b0;
    check("restart_enable", 32'(enable), 32'd1);
    check("restart_game_over", 32'(game_over), 32'd0);
    check("restart_wave", 32'(wave), 32'd0);
    at_cyc(base + 70);
    check("restart_stays_run", 32'(game_over), 32'd0);

    // Mid-run reset with one spawn into the wave.
    at_cyc(base + 77); rst_n = 1'b0;
    at_cyc(base + 78);
    check("mrst_spawn", 32'(spawn), 32'd0);
    check("mrst_rand", 32'(rand_bits), 32'd0);
    check("mrst_enable", 32'(enable), 32'd0);
    check("mrst_game_over", 32'(game_over), 32'd0);
    check("mrst_wave", 32'(wave), 32'd0);
    check("mrst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0000ACE1);
    rst_n = 1'b1;
    at_cyc(base + 100);
    check("idle_enable", 32'(enable), 32'd0);
    check("idle_game_over", 32'(game_over), 32'd0);
    check("missing_spawns", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
